// File: rtl/gwct_pkg.sv
// gwct_pkg: framing constants, status codes, parser state encoding and the
// response-byte selector shared by the command parser.
package gwct_pkg;

  localparam logic [7:0] SYNC_REQ  = 8'hA5;
  localparam logic [7:0] SYNC_RSP  = 8'h5A;
  localparam logic [7:0] OP_READ   = 8'h01;
  localparam logic [7:0] OP_WRITE  = 8'h02;

  localparam logic [7:0] ST_OK     = 8'h00;
  localparam logic [7:0] ST_SLVERR = 8'h01;
  localparam logic [7:0] ST_BAD_OP = 8'h02;

  // Response lengths: sync + status, optionally followed by 4 rdata bytes.
  localparam logic [2:0] RSP_LEN_SHORT = 3'd2;
  localparam logic [2:0] RSP_LEN_READ  = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_OP   = 3'd1,
    S_ADDR = 3'd2,
    S_DATA = 3'd3,
    S_EXEC = 3'd4,
    S_WAIT = 3'd5,
    S_RESP = 3'd6
  } state_e;

  // Byte at position idx of a response frame.
  function automatic logic [7:0] rsp_byte(input logic [2:0]  idx,
                                          input logic [7:0]  status,
                                          input logic [31:0] rdata);
    logic [7:0] b;
    case (idx)
      3'd0:    b = SYNC_RSP;
      3'd1:    b = status;
      3'd2:    b = rdata[7:0];
      3'd3:    b = rdata[15:8];
      3'd4:    b = rdata[23:16];
      3'd5:    b = rdata[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/gwct_cmd_parser.sv
// gwct_cmd_parser: turns a UART byte stream into single APB read/write
// commands and streams back a framed response. Partial packets are dropped
// after an inter-byte timeout; bytes arriving while a command is in flight
// or a response is being sent are discarded and flagged on rx_drop.
module gwct_cmd_parser
  import gwct_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] cmd_addr,
  output logic [31:0] cmd_wdata,
  output logic        cmd_write,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  input  logic [31:0] cmd_rdata,
  input  logic        cmd_error,
  output logic        busy,
  output logic        rx_drop
);

  localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] TO_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e            state_q;
  logic [CNT_W-1:0]  to_cnt_q;
  logic [1:0]        lane_q;
  logic [2:0]        rsp_idx_q;
  logic [2:0]        rsp_len_q;
  logic [7:0]        status_q;
  logic [31:0]       rdata_q;
  logic [7:0]        tx_data_q;
  logic              tx_valid_q;
  logic [31:0]       cmd_addr_q;
  logic [31:0]       cmd_wdata_q;
  logic              cmd_write_q;
  logic              cmd_valid_q;
  logic              busy_q;

  logic              rx_phase;
  logic              drop_phase;

  // Packet-collection states run the inter-byte timeout; command/response
  // states reject incoming bytes.
  assign rx_phase   = (state_q == S_OP) || (state_q == S_ADDR) || (state_q == S_DATA);
  assign drop_phase = (state_q == S_EXEC) || (state_q == S_WAIT) || (state_q == S_RESP);

  assign rx_drop   = rx_valid & drop_phase;
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign cmd_addr  = cmd_addr_q;
  assign cmd_wdata = cmd_wdata_q;
  assign cmd_write = cmd_write_q;
  assign cmd_valid = cmd_valid_q;
  assign busy      = busy_q;

  // Parser FSM with registered outputs and the inter-byte timeout counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      to_cnt_q    <= TO_ZERO;
      lane_q      <= 2'd0;
      rsp_idx_q   <= 3'd0;
      rsp_len_q   <= 3'd0;
      status_q    <= 8'h00;
      rdata_q     <= 32'h0000_0000;
      tx_data_q   <= 8'h00;
      tx_valid_q  <= 1'b0;
      cmd_addr_q  <= 32'h0000_0000;
      cmd_wdata_q <= 32'h0000_0000;
      cmd_write_q <= 1'b0;
      cmd_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rx_valid && (rx_data == SYNC_REQ)) begin
            state_q <= S_OP;
            busy_q  <= 1'b1;
          end
        end
        S_OP: begin
          if (rx_valid) begin
            if ((rx_data == OP_READ) || (rx_data == OP_WRITE)) begin
              cmd_write_q <= (rx_data == OP_WRITE);
              lane_q      <= 2'd0;
              state_q     <= S_ADDR;
            end else begin
              // Unknown opcode: answer immediately, never touch the bus.
              status_q   <= ST_BAD_OP;
              rsp_len_q  <= RSP_LEN_SHORT;
              rsp_idx_q  <= 3'd0;
              tx_data_q  <= SYNC_RSP;
              tx_valid_q <= 1'b1;
              state_q    <= S_RESP;
            end
          end
        end
        S_ADDR: begin
          if (rx_valid) begin
            cmd_addr_q[{lane_q, 3'b000} +: 8] <= rx_data;
            lane_q <= lane_q + 2'd1;
            if (lane_q == 2'd3) begin
              if (cmd_write_q) begin
                state_q <= S_DATA;
              end else begin
                cmd_valid_q <= 1'b1;
                state_q     <= S_EXEC;
              end
            end
          end
        end
        S_DATA: begin
          if (rx_valid) begin
            cmd_wdata_q[{lane_q, 3'b000} +: 8] <= rx_data;
            lane_q <= lane_q + 2'd1;
            if (lane_q == 2'd3) begin
              cmd_valid_q <= 1'b1;
              state_q     <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          cmd_valid_q <= 1'b0;
          state_q     <= S_WAIT;
        end
        S_WAIT: begin
          if (cmd_ready) begin
            rdata_q    <= cmd_rdata;
            status_q   <= cmd_error ? ST_SLVERR : ST_OK;
            rsp_len_q  <= cmd_write_q ? RSP_LEN_SHORT : RSP_LEN_READ;
            rsp_idx_q  <= 3'd0;
            tx_data_q  <= SYNC_RSP;
            tx_valid_q <= 1'b1;
            state_q    <= S_RESP;
          end
        end
        S_RESP: begin
          if (tx_valid_q && tx_ready) begin
            if (rsp_idx_q == (rsp_len_q - 3'd1)) begin
              tx_valid_q <= 1'b0;
              tx_data_q  <= 8'h00;
              rsp_idx_q  <= 3'd0;
              busy_q     <= 1'b0;
              state_q    <= S_IDLE;
            end else begin
              rsp_idx_q <= rsp_idx_q + 3'd1;
              tx_data_q <= rsp_byte(rsp_idx_q + 3'd1, status_q, rdata_q);
            end
          end
        end
        default: begin
          tx_valid_q  <= 1'b0;
          cmd_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase

      // A received byte always restarts the timeout, even on the expiry cycle.
      if (rx_phase) begin
        if (rx_valid) begin
          to_cnt_q <= TO_ZERO;
        end else if (to_cnt_q == TO_LAST) begin
          to_cnt_q <= TO_ZERO;
          lane_q   <= 2'd0;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end else begin
          to_cnt_q <= to_cnt_q + TO_ONE;
        end
      end else begin
        to_cnt_q <= TO_ZERO;
      end
    end
  end

endmodule

// File: tb/tb_gwct_cmd_parser.sv
// tb_gwct_cmd_parser: directed and randomized checks of the command parser
// against a frame-level reference model.
module tb_gwct_cmd_parser;

  typedef logic [7:0] bq_t[$];

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        cmd_write;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [31:0] cmd_rdata = 32'h0;
  logic        cmd_error = 1'b0;
  logic        busy;
  logic        rx_drop;

  int vectors = 0;
  int miscompares = 0;

  // Observation state filled by the monitor.
  bq_t         txq;
  int          cmdv_cnt = 0;
  int          drop_cnt = 0;
  int          stab_viol = 0;
  int          cmd_viol = 0;
  logic [31:0] cap_addr = 32'h0;
  logic [31:0] cap_wdata = 32'h0;
  logic        cap_write = 1'b0;
  logic        cmd_pend = 1'b0;
  logic        prev_hold = 1'b0;
  logic [7:0]  prev_data = 8'h00;
  int          bp_len = 0;
  int          bp_ctr = 0;

  gwct_cmd_parser #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_write(cmd_write),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rdata(cmd_rdata),
    .cmd_error(cmd_error), .busy(busy), .rx_drop(rx_drop)
  );

  always #5 clk = ~clk;

  // Monitor on the falling edge: command capture, tx stream, hold stability.
  always @(negedge clk) begin
    if (rst) begin
      cmd_pend  = 1'b0;
      prev_hold = 1'b0;
    end else begin
      if (cmd_pend && (cmd_addr !== cap_addr || cmd_wdata !== cap_wdata || cmd_write !== cap_write))
        cmd_viol++;
      if (cmd_valid === 1'b1) begin
        cmdv_cnt++;
        cap_addr  = cmd_addr;
        cap_wdata = cmd_wdata;
        cap_write = cmd_write;
        cmd_pend  = 1'b1;
      end
      if (cmd_ready) cmd_pend = 1'b0;
      if (prev_hold && (tx_valid !== 1'b1 || tx_data !== prev_data)) stab_viol++;
      if (tx_valid === 1'b1 && tx_ready) txq.push_back(tx_data);
      prev_hold = (tx_valid === 1'b1) && !tx_ready;
      prev_data = tx_data;
      if (rx_drop === 1'b1) drop_cnt++;
    end
  end

  // Transmitter model: holds tx_ready low bp_len cycles per offered byte.
  always @(posedge clk) begin
    #1;
    if (tx_valid !== 1'b1 || tx_ready) begin
      tx_ready = 1'b0;
      bp_ctr   = 0;
    end else if (bp_ctr >= bp_len) begin
      tx_ready = 1'b1;
    end else begin
      bp_ctr++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  // Reference model: the response frame the spec's rules produce.
  function automatic bq_t model_resp(input logic [7:0] op, input logic [31:0] rdata, input bit err);
    bq_t q;
    q.push_back(8'h5A);
    if (op != 8'h01 && op != 8'h02) q.push_back(8'h02);
    else q.push_back(err ? 8'h01 : 8'h00);
    if (op == 8'h01)
      for (int i = 0; i < 4; i++) q.push_back(rdata[8*i +: 8]);
    return q;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_packet(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wdata);
    send_byte(8'hA5);
    send_byte(op);
    if (op == 8'h01 || op == 8'h02) begin
      for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
      if (op == 8'h02)
        for (int i = 0; i < 4; i++) send_byte(wdata[8*i +: 8]);
    end
  endtask

  task automatic wait_cmd(input int base, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (cmdv_cnt > base) begin
        ok = 1'b1;
        break;
      end
      idle(1);
    end
  endtask

  task automatic pulse_ready(input logic [31:0] rdata, input bit err);
    cmd_rdata = rdata;
    cmd_error = err;
    cmd_ready = 1'b1;
    idle(1);
    cmd_ready = 1'b0;
    cmd_error = 1'b0;
  endtask

  task automatic collect(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (txq.size() >= n && busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      idle(1);
    end
  endtask

  task automatic test_reset();
    int dbase;
    idle(3);
    rst = 1'b0;
    idle(1);
    vectors++; if (tx_data !== 8'h00) begin miscompares++; $display("FAIL rst_tx_data: got %h expected 00", tx_data); end
    vectors++; if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL rst_tx_valid: got %b expected 0", tx_valid); end
    vectors++; if (cmd_addr !== 32'h0) begin miscompares++; $display("FAIL rst_cmd_addr: got %h expected 0", cmd_addr); end
    vectors++; if (cmd_wdata !== 32'h0) begin miscompares++; $display("FAIL rst_cmd_wdata: got %h expected 0", cmd_wdata); end
    vectors++; if (cmd_write !== 1'b0) begin miscompares++; $display("FAIL rst_cmd_write: got %b expected 0", cmd_write); end
    vectors++; if (cmd_valid !== 1'b0) begin miscompares++; $display("FAIL rst_cmd_valid: got %b expected 0", cmd_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b expected 0", busy); end
    vectors++; if (rx_drop !== 1'b0) begin miscompares++; $display("FAIL rst_rx_drop: got %b expected 0", rx_drop); end
    // Stray cmd_ready and a non-sync byte in IDLE must do nothing.
    dbase = drop_cnt;
    txq.delete();
    pulse_ready(32'h1234_5678, 1'b0);
    send_byte(8'h3C);
    idle(5);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy: got %b expected 0", busy); end
    vectors++; if (txq.size() != 0) begin miscompares++; $display("FAIL idle_no_resp: got %0d bytes expected 0", txq.size()); end
    vectors++; if (drop_cnt != dbase) begin miscompares++; $display("FAIL idle_no_drop: got %0d drops expected 0", drop_cnt - dbase); end
  endtask

  task automatic test_read();
    int base; bit ok; bq_t exp;
    base = cmdv_cnt; txq.delete(); bp_len = 0;
    send_packet(8'h01, 32'h4000_0010, 32'h0);
    wait_cmd(base, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL read_cmd_valid: got 0 pulses expected 1"); end
    vectors++; if (cap_addr !== 32'h4000_0010) begin miscompares++; $display("FAIL read_addr: got %h expected 40000010", cap_addr); end
    vectors++; if (cap_write !== 1'b0) begin miscompares++; $display("FAIL read_write: got %b expected 0", cap_write); end
    idle(2);
    pulse_ready(32'hDEAD_BEEF, 1'b0);
    collect(6, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL read_resp_done: got %0d bytes busy=%b, expected 6 and idle", txq.size(), busy); end
    vectors++; if (cmdv_cnt - base != 1) begin miscompares++; $display("FAIL read_one_pulse: got %0d pulses expected 1", cmdv_cnt - base); end
    exp = {8'h5A, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    vectors++;
    if (txq.size() != exp.size()) begin miscompares++; $display("FAIL read_resp_len: got %0d expected %0d", txq.size(), exp.size()); end
    else for (int i = 0; i < exp.size(); i++) begin
      vectors++;
      if (txq[i] !== exp[i]) begin miscompares++; $display("FAIL read_resp_byte%0d: got %h expected %h", i, txq[i], exp[i]); end
    end
  endtask

  task automatic test_write();
    int base; bit ok; bq_t exp;
    base = cmdv_cnt; txq.delete(); bp_len = 1;
    send_packet(8'h02, 32'h4000_0004, 32'h1234_5678);
    wait_cmd(base, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL write_cmd_valid: got 0 pulses expected 1"); end
    vectors++; if (cap_addr !== 32'h4000_0004) begin miscompares++; $display("FAIL write_addr: got %h expected 40000004", cap_addr); end
    vectors++; if (cap_wdata !== 32'h1234_5678) begin miscompares++; $display("FAIL write_wdata: got %h expected 12345678", cap_wdata); end
    vectors++; if (cap_write !== 1'b1) begin miscompares++; $display("FAIL write_write: got %b expected 1", cap_write); end
    idle(3);
    pulse_ready(32'hFFFF_FFFF, 1'b1);
    collect(2, ok);
    exp = {8'h5A, 8'h01};
    vectors++;
    if (!ok || txq.size() != exp.size()) begin miscompares++; $display("FAIL write_resp_len: got %0d expected %0d", txq.size(), exp.size()); end
    else for (int i = 0; i < exp.size(); i++) begin
      vectors++;
      if (txq[i] !== exp[i]) begin miscompares++; $display("FAIL write_resp_byte%0d: got %h expected %h", i, txq[i], exp[i]); end
    end
    vectors++; if (cmd_viol != 0) begin miscompares++; $display("FAIL cmd_stable: got %0d changes expected 0", cmd_viol); end
  endtask

  task automatic test_bad_op();
    int base; bit ok; bq_t exp;
    base = cmdv_cnt; txq.delete(); bp_len = 0;
    send_packet(8'h07, 32'h0, 32'h0);
    collect(2, ok);
    idle(3);
    vectors++; if (cmdv_cnt != base) begin miscompares++; $display("FAIL badop_no_cmd: got %0d pulses expected 0", cmdv_cnt - base); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL badop_idle: got busy %b expected 0", busy); end
    exp = {8'h5A, 8'h02};
    vectors++;
    if (!ok || txq.size() != exp.size()) begin miscompares++; $display("FAIL badop_resp_len: got %0d expected %0d", txq.size(), exp.size()); end
    else for (int i = 0; i < exp.size(); i++) begin
      vectors++;
      if (txq[i] !== exp[i]) begin miscompares++; $display("FAIL badop_resp_byte%0d: got %h expected %h", i, txq[i], exp[i]); end
    end
  endtask

  task automatic test_timeout();
    int base; bit ok; bq_t exp; logic [31:0] addr; logic [31:0] rdata;
    base = cmdv_cnt; txq.delete(); bp_len = 0;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10);
    idle(10);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL to_still_busy: got %b expected 1", busy); end
    idle(10);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL to_expired: got busy %b expected 0", busy); end
    vectors++; if (txq.size() != 0 || cmdv_cnt != base) begin miscompares++; $display("FAIL to_discard: got %0d bytes %0d cmds expected 0 0", txq.size(), cmdv_cnt - base); end
    // Slow but in-time packet; address bytes equal to the sync value are data.
    addr = 32'hA500_A5A5; rdata = $urandom;
    send_byte(8'hA5); idle(12);
    send_byte(8'h01); idle(12);
    for (int i = 0; i < 4; i++) begin
      send_byte(addr[8*i +: 8]);
      idle(12);
    end
    vectors++; if (cmdv_cnt - base != 1 || cap_addr !== addr) begin miscompares++; $display("FAIL to_slow_pkt: got %0d cmds addr %h expected 1 %h", cmdv_cnt - base, cap_addr, addr); end
    pulse_ready(rdata, 1'b0);
    collect(6, ok);
    exp = model_resp(8'h01, rdata, 1'b0);
    vectors++;
    if (!ok || txq.size() != exp.size()) begin miscompares++; $display("FAIL to_resp_len: got %0d expected %0d", txq.size(), exp.size()); end
    else for (int i = 0; i < exp.size(); i++) begin
      vectors++;
      if (txq[i] !== exp[i]) begin miscompares++; $display("FAIL to_resp_byte%0d: got %h expected %h", i, txq[i], exp[i]); end
    end
  endtask

  task automatic test_backpressure();
    int base; int dbase; int sbase; bit ok; bq_t exp; logic [31:0] addr; logic [31:0] rdata;
    base = cmdv_cnt; dbase = drop_cnt; sbase = stab_viol; txq.delete(); bp_len = 5;
    addr = $urandom; rdata = $urandom;
    send_packet(8'h01, addr, 32'h0);
    wait_cmd(base, ok);
    pulse_ready(rdata, 1'b0);
    idle(2);
    send_byte(8'h33);
    collect(6, ok);
    bp_len = 0;
    vectors++; if (drop_cnt - dbase != 1) begin miscompares++; $display("FAIL bp_rx_drop: got %0d pulses expected 1", drop_cnt - dbase); end
    vectors++; if (stab_viol != sbase) begin miscompares++; $display("FAIL bp_tx_stable: got %0d violations expected 0", stab_viol - sbase); end
    exp = model_resp(8'h01, rdata, 1'b0);
    vectors++;
    if (!ok || txq.size() != exp.size()) begin miscompares++; $display("FAIL bp_resp_len: got %0d expected %0d", txq.size(), exp.size()); end
    else for (int i = 0; i < exp.size(); i++) begin
      vectors++;
      if (txq[i] !== exp[i]) begin miscompares++; $display("FAIL bp_resp_byte%0d: got %h expected %h", i, txq[i], exp[i]); end
    end
  endtask

  task automatic test_reset_in_wait();
    int base; bit ok;
    base = cmdv_cnt; txq.delete();
    send_packet(8'h01, 32'h0000_0100, 32'h0);
    wait_cmd(base, ok);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstwait_busy: got %b expected 0", busy); end
    vectors++; if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL rstwait_tx_valid: got %b expected 0", tx_valid); end
    pulse_ready(32'hCAFE_F00D, 1'b0);
    idle(10);
    vectors++; if (txq.size() != 0 || busy !== 1'b0) begin miscompares++; $display("FAIL rstwait_no_resp: got %0d bytes busy %b expected 0 0", txq.size(), busy); end
  endtask

  task automatic test_random();
    int base; int dbase; int exp_drop; int lat; int sel; bit ok; bit err; bit vop; bq_t exp;
    logic [7:0] op; logic [7:0] junk; logic [31:0] addr; logic [31:0] wdata; logic [31:0] rdata;
    for (int it = 0; it < 40; it++) begin
      sel = $urandom_range(0, 9);
      op = (sel < 4) ? 8'h01 : (sel < 8) ? 8'h02 : 8'($urandom_range(3, 255));
      vop = (op == 8'h01 || op == 8'h02);
      addr = $urandom; wdata = $urandom; rdata = $urandom;
      err = 1'($urandom_range(0, 1)); lat = $urandom_range(0, 3); bp_len = $urandom_range(0, 3);
      junk = 8'($urandom_range(0, 255));
      if (junk == 8'hA5) junk = 8'h00;
      base = cmdv_cnt; dbase = drop_cnt; exp_drop = 0; txq.delete();
      send_byte(junk);
      send_packet(op, addr, wdata);
      if (vop) begin
        wait_cmd(base, ok);
        vectors++;
        if (!ok || cap_addr !== addr || cap_write !== (op == 8'h02) || (op == 8'h02 && cap_wdata !== wdata)) begin
          miscompares++;
          $display("FAIL rnd%0d_cmd: got a=%h w=%b d=%h expected a=%h w=%b d=%h", it, cap_addr, cap_write, cap_wdata, addr, op == 8'h02, wdata);
        end
        if (lat > 0) begin
          send_byte(8'($urandom_range(0, 255)));
          exp_drop++;
          idle(lat - 1);
        end
        pulse_ready(rdata, err);
      end
      exp = model_resp(op, rdata, err);
      collect(exp.size(), ok);
      vectors++; if (cmdv_cnt - base != (vop ? 1 : 0)) begin miscompares++; $display("FAIL rnd%0d_cmd_count: got %0d expected %0d", it, cmdv_cnt - base, vop ? 1 : 0); end
      vectors++; if (drop_cnt - dbase != exp_drop) begin miscompares++; $display("FAIL rnd%0d_drops: got %0d expected %0d", it, drop_cnt - dbase, exp_drop); end
      vectors++;
      if (!ok || txq.size() != exp.size()) begin miscompares++; $display("FAIL rnd%0d_resp_len: got %0d expected %0d", it, txq.size(), exp.size()); end
      else for (int i = 0; i < exp.size(); i++) begin
        vectors++;
        if (txq[i] !== exp[i]) begin miscompares++; $display("FAIL rnd%0d_resp_byte%0d: got %h expected %h", it, i, txq[i], exp[i]); end
      end
    end
    bp_len = 0;
    vectors++; if (stab_viol != 0 || cmd_viol != 0) begin miscompares++; $display("FAIL rnd_stability: got %0d tx %0d cmd violations expected 0", stab_viol, cmd_viol); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_bad_op();
    test_timeout();
    test_backpressure();
    test_reset_in_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gwct_cmd_parser.md
GWCT_CMD_PARSER -- requirements
Module: gwct_cmd_parser

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 100000: inter-byte timeout in clk cycles while a packet is partially received.
REQ-002 clk  input  1  sole clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 rx_data  input  8  received byte from UART receiver.
REQ-005 rx_valid  input  1  one-cycle strobe: rx_data valid.
REQ-006 tx_data  output  8  response byte to UART transmitter.
REQ-007 tx_valid  output  1  tx_data valid; held until tx_ready.
REQ-008 tx_ready  input  1  transmitter accepts tx_data this cycle.
REQ-009 cmd_addr  output  32  APB address to the APB master.
REQ-010 cmd_wdata  output  32  APB write data.
REQ-011 cmd_write  output  1  1 = write, 0 = read.
REQ-012 cmd_valid  output  1  one-cycle pulse: start transaction.
REQ-013 cmd_ready  input  1  one-cycle pulse: transaction complete.
REQ-014 cmd_rdata  input  32  read data, valid with cmd_ready.
REQ-015 cmd_error  input  1  PSLVERR status, valid with cmd_ready.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 rx_drop  output  1  one-cycle pulse: rx byte discarded (EXEC/WAIT/RESP states).

Function
REQ-018 Request packet: 0xA5 sync, op byte (0x01 read, 0x02 write), 4 address bytes LSB first, then 4 write-data bytes LSB first (write only).
REQ-019 Response: 0x5A, status byte (0x00 OK, 0x01 SLVERR, 0x02 BAD_OP), then 4 rdata bytes LSB first only for successful-or-errored reads; writes and BAD_OP return 2 bytes.
REQ-020 States: IDLE, OP, ADDR, DATA, EXEC, WAIT, RESP.
REQ-021 IDLE: byte 0xA5 -> OP; any other byte ignored silently (no rx_drop).
REQ-022 OP: 0x01/0x02 -> latch cmd_write, ADDR; any other value -> RESP with status BAD_OP, no APB access.
REQ-023 ADDR: shift 4 bytes into cmd_addr byte lanes 0..3 using 2-bit counter; after 4th byte -> DATA if write, else EXEC.
REQ-024 DATA: same for cmd_wdata; after 4th byte -> EXEC.
REQ-025 EXEC: cmd_valid high exactly one cycle -> WAIT; cmd_addr/cmd_wdata/cmd_write stable from EXEC until cmd_ready.
REQ-026 WAIT: on cmd_ready latch cmd_rdata and status (cmd_error ? SLVERR : OK) -> RESP; no timeout in WAIT.
REQ-027 RESP: present bytes sequentially; a byte advances only on tx_valid & tx_ready; tx_data stable while tx_valid & !tx_ready; after final byte accepted tx_valid drops the next cycle -> IDLE.
REQ-028 Timeout: in OP/ADDR/DATA, counter clears on each rx_valid; reaching TIMEOUT_CYCLES-1 cycles with no byte -> IDLE, partial packet discarded, no response.
REQ-029 rx_valid in EXEC/WAIT/RESP: byte discarded, rx_drop pulses same cycle.
REQ-030 Simultaneous timeout expiry and rx_valid: byte wins, counter clears.
REQ-031 0xA5 received mid-packet is treated as data, not resync.
REQ-032 Counter widths: timeout counter $clog2(TIMEOUT_CYCLES)+1 bits; byte index 3 bits (max 6 response bytes).

Reset
REQ-033 rst in any state, including WAIT or mid-RESP, -> IDLE next edge; pending response abandoned.
REQ-034 Reset values: tx_data 0, tx_valid 0, cmd_addr 0, cmd_wdata 0, cmd_write 0, cmd_valid 0, busy 0, rx_drop 0; all counters 0.
REQ-035 cmd_ready arriving after reset is ignored in IDLE.

Structure
REQ-036 Shared package gwct_pkg holds SYNC_REQ 0xA5, SYNC_RSP 0x5A, OP_READ 0x01, OP_WRITE 0x02, status codes and state encoding.
REQ-037 Single flat module; no sub-modules.

Verification
REQ-038 Read: A5 01 10 00 00 40 -> cmd_addr 0x40000010, cmd_write 0, one cmd_valid; cmd_ready with cmd_rdata 0xDEADBEEF -> tx 5A 00 EF BE AD DE.
REQ-039 Write: A5 02 04 00 00 40 78 56 34 12 -> cmd_addr 0x40000004, cmd_wdata 0x12345678, cmd_write 1; cmd_ready, cmd_error 1 -> tx 5A 01.
REQ-040 Bad op: A5 07 -> no cmd_valid; tx 5A 02; return to IDLE.
REQ-041 Timeout (TIMEOUT_CYCLES=16): A5 01 10 then 20 idle cycles -> IDLE, no response; new full read packet processed normally.
REQ-042 Backpressure: tx_ready low 5 cycles per byte during response -> tx_data stable, each byte sent once, order intact; rx byte during RESP -> rx_drop pulse.
REQ-043 Reset in WAIT: after A5 01 ... EXEC, assert rst -> busy 0, tx_valid 0; later cmd_ready produces no response.
